// File: rtl/decoder_stream_controller_if.sv
// Handshake bundle between the decoder stream controller, the syndrome
// buffer, the decoder input/output FIFOs and the result consumer.
interface decoder_stream_controller_if #(
  parameter int PAYLOAD_BYTES = 3
);
  logic [PAYLOAD_BYTES*8-1:0] meas_data;
  logic                       meas_valid;
  logic                       meas_ready;
  logic [7:0]                 dec_in_data;
  logic                       dec_in_valid;
  logic                       dec_in_ready;
  logic [7:0]                 dec_out_data;
  logic                       dec_out_valid;
  logic                       dec_out_ready;
  logic [7:0]                 result_iterations;
  logic [15:0]                result_cycles;
  logic                       result_valid;
  logic                       result_ready;

  modport master (
    input  meas_data, meas_valid, dec_in_ready, dec_out_data, dec_out_valid, result_ready,
    output meas_ready, dec_in_data, dec_in_valid, dec_out_ready,
    output result_iterations, result_cycles, result_valid
  );

  modport slave (
    output meas_data, meas_valid, dec_in_ready, dec_out_data, dec_out_valid, result_ready,
    input  meas_ready, dec_in_data, dec_in_valid, dec_out_ready,
    input  result_iterations, result_cycles, result_valid
  );
endinterface

// File: rtl/decoder_stream_controller.sv
// Sequences one decoder: start message once, then header + syndrome bytes per
// job, then collects the 3-byte response and publishes it as a result word.
module decoder_stream_controller #(
  parameter int         GRID_WIDTH_X            = 4,
  parameter int         GRID_WIDTH_Z            = 1,
  parameter int         GRID_WIDTH_U            = 3,
  parameter int         TIMEOUT_CYCLES          = 4096,
  parameter logic [7:0] START_DECODING_MSG      = 8'h01,
  parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02
) (
  input  logic                        clk,
  input  logic                        reset,
  decoder_stream_controller_if.master bus,
  output logic [15:0]                 job_count,
  output logic                        timeout_err
);
  localparam int BYTES_PER_ROUND = (GRID_WIDTH_X*GRID_WIDTH_Z+7)>>3;
  localparam int PAYLOAD_BYTES   = BYTES_PER_ROUND*GRID_WIDTH_U;
  localparam int IDX_W           = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TMR_W           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BYTES-1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {
    ST_RST, ST_START, ST_IDLE, ST_HDR, ST_PAY, ST_WAIT, ST_RSP, ST_PUB
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       payload_reg [PAYLOAD_BYTES];
  logic [IDX_W-1:0] idx_reg;
  logic [1:0]       cnt_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [7:0]       iter_reg;
  logic [15:0]      cycles_reg;
  logic [15:0]      job_count_reg;
  logic             timeout_err_reg;

  logic       meas_ready_int, in_valid_int, out_ready_int, res_valid_int;
  logic [7:0] in_data_int;
  logic       meas_xfer, in_xfer, out_xfer, res_xfer;

  assign meas_xfer = meas_ready_int & bus.meas_valid;
  assign in_xfer   = in_valid_int   & bus.dec_in_ready;
  assign out_xfer  = out_ready_int  & bus.dec_out_valid;
  assign res_xfer  = res_valid_int  & bus.result_ready;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_RST;
    else       state_reg <= state_next;
  end

  // Handshake outputs are pure functions of the state, so dec_in_data stays
  // put while a byte is stalled and result fields only change outside PUB.
  always_comb begin
    state_next     = state_reg;
    meas_ready_int = 1'b0;
    in_valid_int   = 1'b0;
    in_data_int    = 8'h00;
    out_ready_int  = 1'b0;
    res_valid_int  = 1'b0;
    case (state_reg)
      ST_RST: state_next = ST_START;
      ST_START: begin
        in_valid_int = 1'b1;
        in_data_int  = START_DECODING_MSG;
        if (bus.dec_in_ready) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        meas_ready_int = 1'b1;
        out_ready_int  = 1'b1;
        if (bus.meas_valid) state_next = ST_HDR;
      end
      ST_HDR: begin
        in_valid_int = 1'b1;
        in_data_int  = MEASUREMENT_DATA_HEADER;
        if (bus.dec_in_ready) state_next = ST_PAY;
      end
      ST_PAY: begin
        in_valid_int = 1'b1;
        in_data_int  = payload_reg[idx_reg];
        if (bus.dec_in_ready && idx_reg == LAST_IDX) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        out_ready_int = 1'b1;
        if (bus.dec_out_valid)          state_next = ST_RSP;
        else if (timer_reg == LAST_TICK) state_next = ST_PUB;
      end
      ST_RSP: begin
        out_ready_int = 1'b1;
        if (bus.dec_out_valid && cnt_reg == 2'd2) state_next = ST_PUB;
      end
      ST_PUB: begin
        res_valid_int = 1'b1;
        if (bus.result_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg         <= '0;
      cnt_reg         <= '0;
      timer_reg       <= '0;
      iter_reg        <= '0;
      cycles_reg      <= '0;
      job_count_reg   <= '0;
      timeout_err_reg <= 1'b0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) payload_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (meas_xfer)
            for (int i = 0; i < PAYLOAD_BYTES; i++) payload_reg[i] <= bus.meas_data[i*8 +: 8];
        end
        ST_HDR: if (in_xfer) idx_reg <= '0;
        ST_PAY: begin
          if (in_xfer) begin
            idx_reg   <= idx_reg + 1'b1;
            timer_reg <= '0;
          end
        end
        ST_WAIT: begin
          if (out_xfer) begin
            iter_reg <= bus.dec_out_data;
            cnt_reg  <= 2'd1;
          end else if (timer_reg == LAST_TICK) begin
            // Decoder never answered: publish a recognisable all-ones result.
            iter_reg        <= 8'hFF;
            cycles_reg      <= 16'hFFFF;
            timeout_err_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_RSP: begin
          if (out_xfer) begin
            if (cnt_reg == 2'd1) cycles_reg[15:8] <= bus.dec_out_data;
            else                 cycles_reg[7:0]  <= bus.dec_out_data;
            cnt_reg <= cnt_reg + 2'd1;
          end
        end
        ST_PUB: if (res_xfer) job_count_reg <= job_count_reg + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.meas_ready        = meas_ready_int;
  assign bus.dec_in_valid      = in_valid_int;
  assign bus.dec_in_data       = in_data_int;
  assign bus.dec_out_ready     = out_ready_int;
  assign bus.result_valid      = res_valid_int;
  assign bus.result_iterations = iter_reg;
  assign bus.result_cycles     = cycles_reg;
  assign job_count             = job_count_reg;
  assign timeout_err           = timeout_err_reg;
endmodule

// File: tb/tb_decoder_stream_controller.sv
// Scoreboard bench: stimulus pushes expected bytes/results into queues, a
// negedge monitor pops and compares on every DUT handshake.
module tb_decoder_stream_controller;
  localparam int GX  = 4;
  localparam int GZ  = 1;
  localparam int GU  = 3;
  localparam int TMO = 16;
  localparam int BPR = (GX*GZ+7)>>3;
  localparam int PB  = BPR*GU;
  localparam int PW  = PB*8;
  localparam logic [7:0] START_MSG = 8'h01;
  localparam logic [7:0] HDR_MSG   = 8'h02;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] job_count;
  logic        timeout_err;

  decoder_stream_controller_if #(.PAYLOAD_BYTES(PB)) bus();

  decoder_stream_controller #(
    .GRID_WIDTH_X(GX), .GRID_WIDTH_Z(GZ), .GRID_WIDTH_U(GU), .TIMEOUT_CYCLES(TMO),
    .START_DECODING_MSG(START_MSG), .MEASUREMENT_DATA_HEADER(HDR_MSG)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .job_count(job_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] data; bit last;} in_exp_t;
  typedef struct {bit has_resp; logic [7:0] b0; logic [7:0] b1; logic [7:0] b2;} resp_t;
  typedef struct {logic [7:0] iter; logic [15:0] cyc; bit tmo;} res_t;

  in_exp_t    exp_in_q[$];
  resp_t      pend_q[$];
  logic [7:0] resp_q[$];
  res_t       exp_res_q[$];
  bit         in_rdy_pat[$];

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model_jc = 16'd0;
  bit          model_tmo = 1'b0;
  bit          jc_chk = 1'b0;
  int          in_rdy_mode = 0;
  int          res_rdy_mode = 0;
  bit          out_xfer_seen = 1'b0;
  int          resp_delay = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Ready drivers for the decoder input FIFO and the result consumer.
  always @(posedge clk) begin
    #1;
    if (in_rdy_pat.size() > 0)  bus.dec_in_ready = in_rdy_pat.pop_front();
    else if (in_rdy_mode == 1)  bus.dec_in_ready = 1'($urandom_range(0, 1));
    else                        bus.dec_in_ready = 1'b1;
    bus.result_ready = (res_rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Decoder output FIFO model: offers queued response bytes with random gaps.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      bus.dec_out_valid = 1'b0;
      resp_delay = 0;
    end else begin
      if (bus.dec_out_valid && out_xfer_seen) begin
        bus.dec_out_valid = 1'b0;
        if (resp_q.size() > 0) void'(resp_q.pop_front());
        resp_delay = int'($urandom_range(0, 3));
      end
      if (!bus.dec_out_valid && resp_q.size() > 0) begin
        if (resp_delay == 0) begin
          bus.dec_out_valid = 1'b1;
          bus.dec_out_data  = resp_q[0];
        end else begin
          resp_delay--;
        end
      end
    end
  end

  in_exp_t     mon_e;
  resp_t       mon_r;
  res_t        mon_x;
  bit          prev_in_stall = 1'b0;
  bit          prev_res_stall = 1'b0;
  logic [7:0]  prev_in_data;
  logic [23:0] prev_res;

  always @(negedge clk) begin
    out_xfer_seen = 1'b0;
    if (reset) begin
      prev_in_stall  = 1'b0;
      prev_res_stall = 1'b0;
      jc_chk         = 1'b0;
    end else begin
      if (jc_chk) begin
        check("job_count", 32'(job_count), 32'(model_jc));
        jc_chk = 1'b0;
      end
      if (prev_in_stall)
        check("dec_in_hold", 32'({bus.dec_in_valid, bus.dec_in_data}), 32'({1'b1, prev_in_data}));
      if (prev_res_stall)
        check("result_hold", 32'({bus.result_valid, bus.result_iterations, bus.result_cycles}),
              32'({1'b1, prev_res}));
      if (bus.dec_in_valid && bus.dec_in_ready) begin
        if (exp_in_q.size() == 0) begin
          check("dec_in_unexpected", 32'({1'b1, bus.dec_in_data}), 32'd0);
        end else begin
          mon_e = exp_in_q.pop_front();
          check("dec_in_data", 32'(bus.dec_in_data), 32'(mon_e.data));
          if (mon_e.last && pend_q.size() > 0) begin
            mon_r = pend_q.pop_front();
            if (mon_r.has_resp) begin
              resp_q.push_back(mon_r.b0);
              resp_q.push_back(mon_r.b1);
              resp_q.push_back(mon_r.b2);
            end
          end
        end
      end
      if (bus.dec_out_valid && bus.dec_out_ready) out_xfer_seen = 1'b1;
      if (bus.result_valid && bus.result_ready) begin
        if (exp_res_q.size() == 0) begin
          check("result_unexpected", 32'({bus.result_iterations, bus.result_cycles}), 32'hFFFF_FFFF);
        end else begin
          mon_x = exp_res_q.pop_front();
          check("result_iterations", 32'(bus.result_iterations), 32'(mon_x.iter));
          check("result_cycles", 32'(bus.result_cycles), 32'(mon_x.cyc));
          model_tmo = model_tmo | mon_x.tmo;
          check("timeout_err", 32'(timeout_err), 32'(model_tmo));
          model_jc = model_jc + 16'd1;
          jc_chk = 1'b1;
        end
      end
      prev_in_stall  = bus.dec_in_valid && !bus.dec_in_ready;
      prev_in_data   = bus.dec_in_data;
      prev_res_stall = bus.result_valid && !bus.result_ready;
      prev_res       = {bus.result_iterations, bus.result_cycles};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_in_q.delete();
    pend_q.delete();
    resp_q.delete();
    exp_res_q.delete();
    in_rdy_pat.delete();
    in_rdy_mode = 0;
    res_rdy_mode = 0;
    model_jc = 16'd0;
    model_tmo = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_meas_ready", 32'(bus.meas_ready), 32'd0);
    check("rst_dec_in_valid", 32'(bus.dec_in_valid), 32'd0);
    check("rst_dec_out_ready", 32'(bus.dec_out_ready), 32'd0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_dec_in_data", 32'(bus.dec_in_data), 32'd0);
    check("rst_result_iterations", 32'(bus.result_iterations), 32'd0);
    check("rst_result_cycles", 32'(bus.result_cycles), 32'd0);
    check("rst_job_count", 32'(job_count), 32'd0);
    exp_in_q.push_back('{START_MSG, 1'b0});
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_cycle_in_valid", 32'(bus.dec_in_valid), 32'd0);
    @(negedge clk);
    check("start_valid", 32'(bus.dec_in_valid), 32'd1);
    check("start_data", 32'(bus.dec_in_data), 32'(START_MSG));
    @(negedge clk);
    check("start_one_cycle", 32'(bus.dec_in_valid), 32'd0);
    check("idle_meas_ready", 32'(bus.meas_ready), 32'd1);
    tick();
  endtask

  task automatic send_job(input logic [PW-1:0] data, input bit has_resp,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input bit timing_chk, input bit toggle);
    bit         accepted;
    logic [7:0] exp_b;
    exp_in_q.push_back('{HDR_MSG, 1'b0});
    for (int k = 0; k < PB; k++) exp_in_q.push_back('{data[k*8 +: 8], (k == PB-1)});
    pend_q.push_back('{has_resp, b0, b1, b2});
    if (has_resp) exp_res_q.push_back('{b0, {b1, b2}, 1'b0});
    else          exp_res_q.push_back('{8'hFF, 16'hFFFF, 1'b1});
    bus.meas_data  = data;
    bus.meas_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      if (bus.meas_ready) accepted = 1'b1;
    end
    check("meas_accept", 32'(accepted), 32'd1);
    if (toggle) begin
      in_rdy_pat.push_back(1'b1);
      in_rdy_pat.push_back(1'b1);
      in_rdy_pat.push_back(1'b0);
      in_rdy_pat.push_back(1'b0);
      in_rdy_pat.push_back(1'b1);
      in_rdy_pat.push_back(1'b0);
      in_rdy_pat.push_back(1'b1);
    end
    tick();
    bus.meas_valid = 1'b0;
    bus.meas_data  = PW'($urandom);
    if (timing_chk) begin
      for (int k = 0; k <= PB; k++) begin
        if (k > 0) @(negedge clk);
        else       @(negedge clk);
        exp_b = (k == 0) ? HDR_MSG : data[(k-1)*8 +: 8];
        check("seq_valid", 32'(bus.dec_in_valid), 32'd1);
        check("seq_data", 32'(bus.dec_in_data), 32'(exp_b));
      end
      @(negedge clk);
      check("wait_out_ready", 32'(bus.dec_out_ready), 32'd1);
      check("wait_in_valid", 32'(bus.dec_in_valid), 32'd0);
    end
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      done = (exp_in_q.size() == 0) && (exp_res_q.size() == 0) && (pend_q.size() == 0) &&
             (resp_q.size() == 0) && !bus.dec_out_valid;
    end
    check(name, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    tick();
  endtask

  task automatic rand_job(input bit toggle);
    send_job(PW'($urandom), 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, toggle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    bus.meas_data     = '0;
    bus.meas_valid    = 1'b0;
    bus.dec_in_ready  = 1'b1;
    bus.dec_out_data  = 8'h00;
    bus.dec_out_valid = 1'b0;
    bus.result_ready  = 1'b1;
    do_reset();

    send_job(PW'(24'h050301), 1'b1, 8'h04, 8'h01, 8'h2C, 1'b1, 1'b0);
    wait_idle("job1_done", 200);
    check("job_count_after_1", 32'(job_count), 32'd1);

    rand_job(1'b1);
    wait_idle("toggle_done", 200);

    send_job(PW'($urandom), 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_idle("timeout_done", 200);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);

    for (int k = 0; k < 3; k++) resp_q.push_back(8'($urandom));
    wait_idle("stray_drained", 50);
    repeat (4) @(negedge clk);
    check("no_extra_result", 32'(bus.result_valid), 32'd0);
    tick();
    rand_job(1'b0);
    wait_idle("recover_done", 200);

    in_rdy_mode = 1;
    res_rdy_mode = 1;
    for (int j = 0; j < 25; j++) begin
      rand_job(1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle("random_done", 1000);

    in_rdy_mode = 0;
    res_rdy_mode = 0;
    rand_job(1'b0);
    tick();
    do_reset();
    send_job(PW'($urandom), 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    wait_idle("post_reset_done", 200);

    force dut.job_count_reg = 16'hFFFF;
    tick();
    release dut.job_count_reg;
    model_jc = 16'hFFFF;
    @(negedge clk);
    check("job_count_preload", 32'(job_count), 32'h0000_FFFF);
    tick();
    rand_job(1'b0);
    wait_idle("wrap_done", 200);
    check("job_count_wrapped", 32'(job_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
